// File: rtl/cpu_pkg.sv
// Shared types and constants for the single-cycle 16-bit core: opcodes, branch conditions, flag layout, saturation limits.
// Combinational helper only; no state lives here.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OVF = 3'b110;
    localparam logic [2:0] CC_AL  = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;
    localparam logic [3:0]  NIB_MAX = 4'h7;
    localparam logic [3:0]  NIB_MIN = 4'h8;

    function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] f);
        case (ccc)
            CC_NE:   return !f[FLAG_Z];
            CC_EQ:   return f[FLAG_Z];
            CC_GT:   return !f[FLAG_Z] && !f[FLAG_N];
            CC_LT:   return f[FLAG_N];
            CC_GE:   return f[FLAG_Z] || !f[FLAG_N];
            CC_LE:   return f[FLAG_N] || f[FLAG_Z];
            CC_OVF:  return f[FLAG_V];
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Purely combinational ALU: saturating add/sub, xor, shifts/rotate, nibble-saturating add, byte reduction,
// address generation and byte-lane merges, plus the Z/V/N values and which of them the op may update.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        z,
    output logic        v,
    output logic        n,
    output logic        set_z,
    output logic        set_vn
);

    opcode_t     op_e;
    logic [15:0] sum;
    logic [15:0] diff;
    logic        add_ovf;
    logic        sub_ovf;
    logic [31:0] rot;
    logic [9:0]  red_sum;
    logic [15:0] paddsb;

    assign op_e    = opcode_t'(op);
    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[15] == b[15]) && (sum[15] != a[15]);
    assign sub_ovf = (a[15] != b[15]) && (diff[15] != a[15]);
    assign rot     = {a, a} >> b[3:0];
    assign red_sum = {{2{a[15]}}, a[15:8]} + {{2{a[7]}}, a[7:0]}
                   + {{2{b[15]}}, b[15:8]} + {{2{b[7]}}, b[7:0]};

    always_comb begin
        paddsb = '0;
        for (int i = 0; i < 4; i++) begin
            logic [4:0] ns;
            ns = {a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]};
            if (ns[4] != ns[3]) paddsb[4*i +: 4] = ns[4] ? NIB_MIN : NIB_MAX;
            else                paddsb[4*i +: 4] = ns[3:0];
        end
    end

    always_comb begin
        result = '0;
        v      = 1'b0;
        set_z  = 1'b0;
        set_vn = 1'b0;
        case (op_e)
            OP_ADD: begin
                result = add_ovf ? (a[15] ? SAT_MIN : SAT_MAX) : sum;
                v      = add_ovf;
                set_z  = 1'b1;
                set_vn = 1'b1;
            end
            OP_SUB: begin
                result = sub_ovf ? (a[15] ? SAT_MIN : SAT_MAX) : diff;
                v      = sub_ovf;
                set_z  = 1'b1;
                set_vn = 1'b1;
            end
            OP_XOR:    begin result = a ^ b;                          set_z = 1'b1; end
            OP_SLL:    begin result = a << b[3:0];                    set_z = 1'b1; end
            OP_SRA:    begin result = 16'($signed(a) >>> b[3:0]);     set_z = 1'b1; end
            OP_ROR:    begin result = rot[15:0];                      set_z = 1'b1; end
            OP_RED:    result = {{6{red_sum[9]}}, red_sum};
            OP_PADDSB: result = paddsb;
            OP_LW,
            OP_SW:     result = (a & 16'hFFFE) + b;
            OP_LLB:    result = {a[15:8], b[7:0]};
            OP_LHB:    result = {b[7:0], a[7:0]};
            default:   result = '0;
        endcase
    end

    assign z = (result == 16'h0000);
    assign n = result[15];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle 16-bit load/store core; every instruction fetches, executes and retires in one clk.
// Latency: one clk per instruction; results visible the cycle after retirement.
// No backpressure; imem/dmem contents are preloaded hierarchically by the bench.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int IMEM_AW = 15,
    parameter int DMEM_AW = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc,
    output logic        hlt
);

    logic [15:0] imem [0:(1<<IMEM_AW)-1];
    logic [15:0] dmem [0:(1<<DMEM_AW)-1];
    logic [15:0] regs [0:15];

    logic [15:0] instruction;
    logic        RegWrite, MemRead, MemWrite;
    logic        RR1Mux, RR2Mux, ALUSrcMux, MemtoRegMux, PCSMux, HaltMux, BranchRegMux, BranchMux;
    logic [1:0]  ImmMux;
    logic [3:0]  rr1_reg, rr2_reg, wr_reg;
    logic [15:0] rr1_data, rr2_data, imm_value, alu_b, alu_result, write_data, mem_data;
    logic [15:0] pc_plus2, branch_target, next_pc;
    logic [2:0]  flags;
    logic        branch_taken;
    logic        alu_z, alu_v, alu_n, set_z, set_vn;
    opcode_t     op;
    logic        unused_bits;

    assign instruction = imem[pc[IMEM_AW:1]];
    assign op          = opcode_t'(instruction[15:12]);

    always_comb begin
        RegWrite     = 1'b1;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        RR1Mux       = 1'b0;
        RR2Mux       = 1'b0;
        ImmMux       = 2'd0;
        ALUSrcMux    = 1'b0;
        MemtoRegMux  = 1'b0;
        PCSMux       = 1'b0;
        HaltMux      = 1'b0;
        BranchRegMux = 1'b0;
        BranchMux    = 1'b0;
        case (op)
            OP_SLL, OP_SRA, OP_ROR: ALUSrcMux = 1'b1;
            OP_LW: begin
                MemRead     = 1'b1;
                MemtoRegMux = 1'b1;
                ImmMux      = 2'd1;
                ALUSrcMux   = 1'b1;
            end
            OP_SW: begin
                RegWrite  = 1'b0;
                MemWrite  = 1'b1;
                RR2Mux    = 1'b1;
                ImmMux    = 2'd1;
                ALUSrcMux = 1'b1;
            end
            OP_LLB, OP_LHB: begin
                RR1Mux    = 1'b1;
                ImmMux    = 2'd2;
                ALUSrcMux = 1'b1;
            end
            OP_B: begin
                RegWrite  = 1'b0;
                ImmMux    = 2'd3;
                BranchMux = 1'b1;
            end
            OP_BR: begin
                RegWrite     = 1'b0;
                BranchRegMux = 1'b1;
                BranchMux    = 1'b1;
            end
            OP_PCS: PCSMux = 1'b1;
            OP_HLT: begin
                RegWrite = 1'b0;
                HaltMux  = 1'b1;
            end
            default: ;
        endcase
    end

    // LLB/LHB read their own destination so the untouched byte survives; SW reads its data register from [11:8].
    assign rr1_reg  = RR1Mux ? instruction[11:8] : instruction[7:4];
    assign rr2_reg  = RR2Mux ? instruction[11:8] : instruction[3:0];
    assign wr_reg   = instruction[11:8];
    assign rr1_data = (rr1_reg == 4'd0) ? 16'h0000 : regs[rr1_reg];
    assign rr2_data = (rr2_reg == 4'd0) ? 16'h0000 : regs[rr2_reg];

    always_comb begin
        case (ImmMux)
            2'd0:    imm_value = {12'h000, instruction[3:0]};
            2'd1:    imm_value = {{11{instruction[3]}}, instruction[3:0], 1'b0};
            2'd2:    imm_value = {8'h00, instruction[7:0]};
            default: imm_value = {{6{instruction[8]}}, instruction[8:0], 1'b0};
        endcase
    end

    assign alu_b = ALUSrcMux ? imm_value : rr2_data;

    cpu_alu u_alu (
        .op     (instruction[15:12]),
        .a      (rr1_data),
        .b      (alu_b),
        .result (alu_result),
        .z      (alu_z),
        .v      (alu_v),
        .n      (alu_n),
        .set_z  (set_z),
        .set_vn (set_vn)
    );

    assign mem_data   = dmem[alu_result[DMEM_AW:1]];
    assign pc_plus2   = pc + 16'd2;
    assign write_data = PCSMux ? pc_plus2 : (MemtoRegMux ? mem_data : alu_result);

    assign branch_taken  = BranchMux && cond_met(instruction[11:9], flags);
    assign branch_target = BranchRegMux ? rr1_data : (pc_plus2 + imm_value);
    assign next_pc       = HaltMux ? pc : (branch_taken ? branch_target : pc_plus2);
    assign hlt           = HaltMux;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            flags <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            pc <= next_pc;
            if (RegWrite && (wr_reg != 4'd0)) regs[wr_reg] <= write_data;
            if (set_vn) begin
                flags[FLAG_Z] <= alu_z;
                flags[FLAG_V] <= alu_v;
                flags[FLAG_N] <= alu_n;
            end else if (set_z) begin
                flags[FLAG_Z] <= alu_z;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (MemWrite) dmem[alu_result[DMEM_AW:1]] <= rr2_data;
    end

    assign unused_bits = ^{pc[0], alu_result[0]};

endmodule

// File: tb/tb_cpu_core.sv
// Directed-program bench for cpu_core: loads small programs into imem under reset, steps them a cycle at a time
// and compares pc, probes, registers and memory against hand-computed values.
module tb_cpu_core;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        hlt;

    int checks   = 0;
    int failures = 0;

    cpu_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pc    (pc),
        .hlt   (hlt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic begin_load();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) dut.imem[i] = 16'hF000;
    endtask

    task automatic put(input logic [15:0] byte_addr, input logic [15:0] word);
        dut.imem[byte_addr[15:1]] = word;
    endtask

    task automatic go();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        checks++;
        if (dut.flags !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", dut.flags); end
    endtask

    task automatic test_llb_lhb();
        begin_load();
        put(16'h00, 16'hA134);
        put(16'h02, 16'hB112);
        go();
        checks++;
        if (pc !== 16'h0000) begin failures++; $display("FAIL release_pc got=%h exp=0000", pc); end
        step(2);
        checks++;
        if (pc !== 16'h0004) begin failures++; $display("FAIL llb_lhb_pc got=%h exp=0004", pc); end
        checks++;
        if (dut.regs[1] !== 16'h1234) begin failures++; $display("FAIL llb_lhb_r1 got=%h exp=1234", dut.regs[1]); end
    endtask

    task automatic test_saturation();
        begin_load();
        put(16'h00, 16'hA1FF);
        put(16'h02, 16'hB17F);
        put(16'h04, 16'hA201);
        put(16'h06, 16'h0312);
        put(16'h08, 16'hB480);
        put(16'h0A, 16'h1542);
        put(16'h0C, 16'h0622);
        go();
        step(4);
        checks++;
        if (dut.regs[3] !== 16'h7FFF) begin failures++; $display("FAIL add_sat_r3 got=%h exp=7fff", dut.regs[3]); end
        checks++;
        if (dut.flags !== 3'b010) begin failures++; $display("FAIL add_sat_flags got=%b exp=010", dut.flags); end
        step(2);
        checks++;
        if (dut.regs[5] !== 16'h8000) begin failures++; $display("FAIL sub_sat_r5 got=%h exp=8000", dut.regs[5]); end
        checks++;
        if (dut.flags !== 3'b011) begin failures++; $display("FAIL sub_sat_flags got=%b exp=011", dut.flags); end
        step(1);
        checks++;
        if (dut.regs[6] !== 16'h0002) begin failures++; $display("FAIL add_plain_r6 got=%h exp=0002", dut.regs[6]); end
        checks++;
        if (dut.flags !== 3'b000) begin failures++; $display("FAIL add_plain_flags got=%b exp=000", dut.flags); end
    endtask

    task automatic test_alu_ops();
        begin_load();
        put(16'h00, 16'hA1F0);
        put(16'h02, 16'hB181);
        put(16'h04, 16'hA20F);
        put(16'h06, 16'h2312);
        put(16'h08, 16'h5414);
        put(16'h0A, 16'h4514);
        put(16'h0C, 16'h6618);
        put(16'h0E, 16'h2711);
        put(16'h10, 16'hA903);
        put(16'h12, 16'hB912);
        put(16'h14, 16'h3892);
        put(16'h16, 16'hAB77);
        put(16'h18, 16'hBB77);
        put(16'h1A, 16'h7A11);
        put(16'h1C, 16'h7CBB);
        go();
        step(4);
        checks++;
        if (dut.flags !== 3'b000) begin failures++; $display("FAIL xor_nz_flags got=%b exp=000", dut.flags); end
        step(11);
        checks++;
        if (pc !== 16'h001E) begin failures++; $display("FAIL alu_end_pc got=%h exp=001e", pc); end
        checks++;
        if (dut.regs[3] !== 16'h81FF) begin failures++; $display("FAIL xor_r3 got=%h exp=81ff", dut.regs[3]); end
        checks++;
        if (dut.regs[4] !== 16'hF81F) begin failures++; $display("FAIL sra_r4 got=%h exp=f81f", dut.regs[4]); end
        checks++;
        if (dut.regs[5] !== 16'h1F00) begin failures++; $display("FAIL sll_r5 got=%h exp=1f00", dut.regs[5]); end
        checks++;
        if (dut.regs[6] !== 16'hF081) begin failures++; $display("FAIL ror_r6 got=%h exp=f081", dut.regs[6]); end
        checks++;
        if (dut.regs[8] !== 16'h0024) begin failures++; $display("FAIL red_r8 got=%h exp=0024", dut.regs[8]); end
        checks++;
        if (dut.regs[10] !== 16'h82E0) begin failures++; $display("FAIL paddsb_neg_r10 got=%h exp=82e0", dut.regs[10]); end
        checks++;
        if (dut.regs[12] !== 16'h7777) begin failures++; $display("FAIL paddsb_pos_r12 got=%h exp=7777", dut.regs[12]); end
        checks++;
        if (dut.flags !== 3'b100) begin failures++; $display("FAIL flags_kept got=%b exp=100", dut.flags); end
    endtask

    task automatic test_memory();
        begin_load();
        put(16'h00, 16'hA1EF);
        put(16'h02, 16'hB1BE);
        put(16'h04, 16'h9102);
        put(16'h06, 16'h8402);
        go();
        step(2);
        checks++;
        if (dut.MemWrite !== 1'b1 || dut.MemRead !== 1'b0) begin
            failures++; $display("FAIL sw_ctrl got=w%b r%b exp=w1 r0", dut.MemWrite, dut.MemRead);
        end
        checks++;
        if (dut.RegWrite !== 1'b0) begin failures++; $display("FAIL sw_regwrite got=%b exp=0", dut.RegWrite); end
        step(1);
        checks++;
        if (dut.dmem[2] !== 16'hBEEF) begin failures++; $display("FAIL sw_dmem got=%h exp=beef", dut.dmem[2]); end
        checks++;
        if (dut.MemRead !== 1'b1 || dut.MemWrite !== 1'b0) begin
            failures++; $display("FAIL lw_ctrl got=r%b w%b exp=r1 w0", dut.MemRead, dut.MemWrite);
        end
        checks++;
        if (dut.alu_result !== 16'h0004) begin failures++; $display("FAIL lw_addr got=%h exp=0004", dut.alu_result); end
        step(1);
        checks++;
        if (dut.regs[4] !== 16'hBEEF) begin failures++; $display("FAIL lw_r4 got=%h exp=beef", dut.regs[4]); end
    endtask

    task automatic load_branch_prog(input logic [15:0] br_word);
        begin_load();
        put(16'h00, 16'hA105);
        for (int a = 2; a <= 12; a += 2) put(16'(a), 16'hA900);
        put(16'h0E, 16'h1311);
        put(16'h10, br_word);
        put(16'h18, 16'hA540);
        put(16'h1A, 16'hDE50);
        go();
        step(8);
    endtask

    task automatic test_branches();
        load_branch_prog(16'hC203);
        checks++;
        if (pc !== 16'h0010 || dut.flags !== 3'b100) begin
            failures++; $display("FAIL beq_setup got=pc %h flags %b exp=pc 0010 flags 100", pc, dut.flags);
        end
        checks++;
        if (dut.branch_taken !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b exp=1", dut.branch_taken); end
        step(1);
        checks++;
        if (pc !== 16'h0018) begin failures++; $display("FAIL beq_target got=%h exp=0018", pc); end
        step(2);
        checks++;
        if (pc !== 16'h0040) begin failures++; $display("FAIL br_target got=%h exp=0040", pc); end
        checks++;
        if (hlt !== 1'b1) begin failures++; $display("FAIL br_lands_hlt got=%b exp=1", hlt); end

        load_branch_prog(16'hC003);
        checks++;
        if (dut.branch_taken !== 1'b0) begin failures++; $display("FAIL bne_taken got=%b exp=0", dut.branch_taken); end
        step(1);
        checks++;
        if (pc !== 16'h0012) begin failures++; $display("FAIL bne_fallthru got=%h exp=0012", pc); end
    endtask

    task automatic test_pcs_r0();
        begin_load();
        for (int a = 0; a < 32; a += 2) put(16'(a), 16'hA95A);
        put(16'h20, 16'hE600);
        put(16'h22, 16'hA107);
        put(16'h24, 16'h0011);
        put(16'h26, 16'h0700);
        go();
        step(17);
        checks++;
        if (dut.regs[6] !== 16'h0022) begin failures++; $display("FAIL pcs_r6 got=%h exp=0022", dut.regs[6]); end
        step(2);
        checks++;
        if (pc !== 16'h0026 || dut.rr1_data !== 16'h0000) begin
            failures++; $display("FAIL r0_read got=pc %h data %h exp=pc 0026 data 0000", pc, dut.rr1_data);
        end
        step(1);
        checks++;
        if (dut.regs[7] !== 16'h0000) begin failures++; $display("FAIL r0_sum_r7 got=%h exp=0000", dut.regs[7]); end
    endtask

    task automatic test_halt();
        begin_load();
        for (int a = 0; a < 48; a += 2) put(16'(a), 16'hA95A);
        go();
        step(24);
        checks++;
        if (pc !== 16'h0030 || hlt !== 1'b1) begin
            failures++; $display("FAIL hlt_reach got=pc %h hlt %b exp=pc 0030 hlt 1", pc, hlt);
        end
        for (int k = 0; k < 3; k++) begin
            step(1);
            checks++;
            if (pc !== 16'h0030) begin failures++; $display("FAIL hlt_hold%0d got=%h exp=0030", k, pc); end
        end
        checks++;
        if (dut.regs[9] !== 16'h005A) begin failures++; $display("FAIL pre_reset_r9 got=%h exp=005a", dut.regs[9]); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 16'h0000) begin failures++; $display("FAIL async_reset_pc got=%h exp=0000", pc); end
        checks++;
        if (dut.regs[9] !== 16'h0000) begin failures++; $display("FAIL async_reset_r9 got=%h exp=0000", dut.regs[9]); end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_llb_lhb();
        test_saturation();
        test_alu_ops();
        test_memory();
        test_branches();
        test_pcs_r0();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
